// File: rtl/block_pkg.sv
// block_pkg: constants shared by block_filter, block_unpacker and their benches.
// Lane order: lane index 0 carries the oldest sample (in_4), index 4 the newest (in0).
package block_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LANES      = 5;
    localparam int LANE_W     = 3;

    // Lane indices in emission order, oldest sample first.
    localparam logic [LANE_W-1:0] LANE_IN_4 = 3'd0;
    localparam logic [LANE_W-1:0] LANE_IN_3 = 3'd1;
    localparam logic [LANE_W-1:0] LANE_IN_2 = 3'd2;
    localparam logic [LANE_W-1:0] LANE_IN_1 = 3'd3;
    localparam logic [LANE_W-1:0] LANE_IN0  = 3'd4;

    localparam logic [LANE_W-1:0] LANE_FIRST = LANE_IN_4;
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_IN0;

    // Block FIFO control states, keyed on occupancy.
    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_ACTIVE,
        FIFO_FULL
    } fifo_state_e;

    // Advance a lane index, wrapping after the newest lane.
    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] idx);
        return (idx == LANE_LAST) ? LANE_FIRST : LANE_W'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/block_fifo.sv
// block_fifo: DEPTH-entry store of whole blocks with wrapping read/write
// pointers and an occupancy count. A push while full is ignored.
module block_fifo
    import block_pkg::*;
#(
    parameter int WIDTH = LANES * DATA_W_DEF,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             can_push,
    output logic             not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] occ_nxt;
    fifo_state_e      state;
    fifo_state_e      state_nxt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    // Flags come from the registered state only, so in_ready never depends
    // combinationally on the downstream handshake.
    assign can_push  = (state != FIFO_FULL);
    assign not_empty = (state != FIFO_EMPTY);
    assign do_push   = push && can_push;
    assign do_pop    = pop && not_empty;
    assign head_data = mem[rd_ptr];

    // Block storage: write the accepted block at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is cleared on reset so no block from before reset can ever reach out.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy and control state follow push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            state     <= FIFO_EMPTY;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occupancy <= occ_nxt;
            state     <= state_nxt;
        end
    end

    // Next occupancy and state; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        occ_nxt   = occupancy;
        state_nxt = state;
        unique case ({do_push, do_pop})
            2'b10:   occ_nxt = OCC_W'(occupancy + 1'b1);
            2'b01:   occ_nxt = OCC_W'(occupancy - 1'b1);
            default: occ_nxt = occupancy;
        endcase
        if (occ_nxt == '0) begin
            state_nxt = FIFO_EMPTY;
        end else if (occ_nxt == OCC_FULL) begin
            state_nxt = FIFO_FULL;
        end else begin
            state_nxt = FIFO_ACTIVE;
        end
    end

endmodule

// File: rtl/block_unpacker.sv
// block_unpacker: buffers 5-lane blocks and emits them one sample per
// accepted handshake, oldest lane (in_4) first.
// Optional feature: define BLOCK_UNPACKER_CNT_EN to add the 32-bit
// sample_cnt output counting every consumed sample.
module block_unpacker #(
    parameter int DATA_W = block_pkg::DATA_W_DEF,
    parameter int LANES  = block_pkg::LANES,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [DATA_W-1:0] in_4,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready
`ifdef BLOCK_UNPACKER_CNT_EN
    ,
    output logic [31:0]       sample_cnt
`endif
);

    import block_pkg::*;

    localparam int WIDTH = LANES * DATA_W;

    logic [WIDTH-1:0]  push_data;
    logic [WIDTH-1:0]  head_data;
    logic [LANE_W-1:0] lane_idx;
    logic [DATA_W-1:0] lane_data;
    logic              consume;
    logic              pop;

    // Lane 0 (lowest slice) holds in_4, the oldest sample.
    assign push_data = {in0, in_1, in_2, in_3, in_4};
    assign consume   = out_valid && out_ready;
    assign pop       = consume && (lane_idx == LANE_LAST);

    block_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .can_push  (in_ready),
        .not_empty (out_valid)
    );

    // Select the current lane of the head block.
    always_comb begin
        lane_data = '0;
        unique case (lane_idx)
            LANE_IN_4: lane_data = head_data[0*DATA_W +: DATA_W];
            LANE_IN_3: lane_data = head_data[1*DATA_W +: DATA_W];
            LANE_IN_2: lane_data = head_data[2*DATA_W +: DATA_W];
            LANE_IN_1: lane_data = head_data[3*DATA_W +: DATA_W];
            LANE_IN0:  lane_data = head_data[4*DATA_W +: DATA_W];
            default:   lane_data = '0;
        endcase
    end

    assign out = out_valid ? lane_data : '0;

    // Lane index advances on each consumed sample and wraps as the head block pops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_idx <= LANE_FIRST;
        end else if (consume) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            lane_idx <= next_lane(lane_idx);
        end
    end

`ifdef BLOCK_UNPACKER_CNT_EN
    // Count consumed samples, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
        end else if (consume) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_block_unpacker.sv
// tb_block_unpacker: directed bench with a sample-queue reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_block_unpacker;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in0, in_1, in_2, in_3, in_4;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
`ifdef BLOCK_UNPACKER_CNT_EN
    logic [31:0]       sample_cnt;
`endif

    block_unpacker #(.DATA_W(DATA_W), .LANES(5), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (in0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .in_4      (in_4),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BLOCK_UNPACKER_CNT_EN
        ,
        .sample_cnt(sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a flat queue of samples, oldest first.
    // Blocks held = ceil(samples / 5); a push is accepted while fewer than DEPTH are held.
    logic [DATA_W-1:0] mq[$];
    int unsigned       m_cnt;
    bit                m_ready_now;

    function automatic bit model_ready();
        return ((mq.size() + 4) / 5) < DEPTH;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            m_ready_now = model_ready();
            if (mq.size() != 0 && out_ready) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (in_valid && m_ready_now) begin
                mq.push_back(in_4);
                mq.push_back(in_3);
                mq.push_back(in_2);
                mq.push_back(in_1);
                mq.push_back(in0);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        check("m_out", {16'd0, out}, {16'd0, (mq.size() != 0) ? mq[0] : 16'd0});
        check("m_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
`ifdef BLOCK_UNPACKER_CNT_EN
        check("m_sample_cnt", sample_cnt, m_cnt);
`endif
    end

    // Inputs change 1 time unit after a rising edge; this pushes one block on the next edge.
    task automatic push_block(input logic [15:0] a4, a3, a2, a1, a0);
        in_4 = a4; in_3 = a3; in_2 = a2; in_1 = a1; in0 = a0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [15:0] got[$];
    logic [15:0] prev;
    logic [15:0] exp_v;
    int          bubbles;
    int          sidx;
    int          sent;
    bit          acc;
    logic [15:0] pat [8] = '{1, 0, 1, 0, 1, 1, 1, 1};

    function automatic logic [15:0] stream_val(input int idx);
        return 16'((idx * 977 + 123) % 65536);
    endfunction

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in0 = '0; in_1 = '0; in_2 = '0; in_3 = '0; in_4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        step();

        // Single block, out_ready high: five consecutive samples then empty.
        out_ready = 1'b1;
        push_block(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("single_valid", {31'd0, out_valid}, 32'd1);
            check("single_out", {16'd0, out}, k);
            step();
        end
        @(negedge clk);
        check("single_empty", {31'd0, out_valid}, 32'd0);
        step();

        // Three back-to-back pushes with out_ready low: third is dropped.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_4 = 16'hA0; in_3 = 16'hA1; in_2 = 16'hA2; in_1 = 16'hA3; in0 = 16'hA4;
        step();
        check("full_after1", {31'd0, in_ready}, 32'd1);
        in_4 = 16'hB0; in_3 = 16'hB1; in_2 = 16'hB2; in_1 = 16'hB3; in0 = 16'hB4;
        step();
        check("full_after2", {31'd0, in_ready}, 32'd0);
        in_4 = 16'hC0; in_3 = 16'hC1; in_2 = 16'hC2; in_1 = 16'hC3; in0 = 16'hC4;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out);
            step();
        end
        check("full_count", got.size(), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            exp_v = (i < 5) ? 16'(16'hA0 + i) : 16'(16'hB0 + i - 5);
            check("full_order", {16'd0, got[i]}, {16'd0, exp_v});
        end

        // One block every 5 cycles: no bubble between blocks.
        bubbles = 0;
        for (int b = 0; b < 200; b++) begin
            push_block(16'(1000 + b*5), 16'(1001 + b*5), 16'(1002 + b*5),
                       16'(1003 + b*5), 16'(1004 + b*5));
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (!out_valid) bubbles++;
                step();
            end
        end
        @(negedge clk);
        check("stream_bubbles", bubbles, 32'd0);
        check("stream_last", {16'd0, out}, 32'd1999);
        step();
        @(negedge clk);
        check("stream_drained", {31'd0, out_valid}, 32'd0);
`ifdef BLOCK_UNPACKER_CNT_EN
        check("sample_cnt_total", sample_cnt, 32'd1015);
`endif
        step();

        // Stall toggling mid-block: holds during stalls, no repeat or skip.
        got.delete();
        out_ready = 1'b1;
        push_block(16'h10, 16'h11, 16'h12, 16'h13, 16'h14);
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            out_ready = pat[i][0];
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out);
            if (i > 0 && !pat[i-1][0]) check("stall_hold", {16'd0, out}, {16'd0, prev});
            prev = out;
            step();
        end
        check("stall_count", got.size(), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            check("stall_order", {16'd0, got[i]}, 32'h10 + i);
        end

        // Reset after two samples of a block.
        out_ready = 1'b1;
        push_block(16'h20, 16'h21, 16'h22, 16'h23, 16'h24);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_out", {16'd0, out}, 32'd0);
        in_valid = 1'b1;
        in_4 = 16'hDEAD; in_3 = 16'hDEAD; in_2 = 16'hDEAD; in_1 = 16'hDEAD; in0 = 16'hDEAD;
        step();
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_ignored_in", {31'd0, out_valid}, 32'd0);
`ifdef BLOCK_UNPACKER_CNT_EN
        check("rst_sample_cnt", sample_cnt, 32'd0);
`endif
        step();
        push_block(16'h30, 16'h31, 16'h32, 16'h33, 16'h34);
        @(negedge clk);
        check("rst_next_first", {16'd0, out}, 32'h30);
        for (int c = 0; c < 6; c++) step();

        // Longer stream with irregular out_ready and flow-controlled pushes.
        sent = 0;
        sidx = 0;
        for (int c = 0; c < 400; c++) begin
            out_ready = (c % 3) != 0;
            if (sent < 20) begin
                in_4 = stream_val(sent*5);     in_3 = stream_val(sent*5 + 1);
                in_2 = stream_val(sent*5 + 2); in_1 = stream_val(sent*5 + 3);
                in0  = stream_val(sent*5 + 4);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (out_valid && out_ready) begin
                check("wave_sample", {16'd0, out}, {16'd0, stream_val(sidx)});
                sidx++;
            end
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("wave_count", sidx, 32'd100);
        check("wave_model_empty", mq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/block_unpacker.md
BLOCK_UNPACKER -- requirements
Module: block_unpacker

Interface
- REQ-001: Parameter DATA_W, default 16, sample width in bits.
- REQ-002: Parameter LANES, default 5, samples per block, fixed at 5 (port list is explicit).
- REQ-003: Parameter DEPTH, default 2, block FIFO depth in blocks.
- REQ-004: clk  input  1  single clock; all state updates on posedge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: in0, in_1, in_2, in_3, in_4  input  DATA_W each  block lanes; in_4 is the oldest sample and in0 the newest, matching the block_filter out_* lane order.
- REQ-007: in_valid  input  1  block present on in*.
- REQ-008: in_ready  output  1  block FIFO can accept a block.
- REQ-009: out  output  DATA_W  serial sample.
- REQ-010: out_valid  output  1  out holds a valid sample.
- REQ-011: out_ready  input  1  downstream accepts out.
- REQ-012: sample_cnt  output  32  emitted-sample count; present only with the configuration macro.

Function
- REQ-013: A block is pushed when in_valid && in_ready at posedge; all five lanes are captured together.
- REQ-014: in_ready = (occupancy < DEPTH), combinational from registered occupancy; it has no same-cycle dependence on out_ready.
- REQ-015: out_valid = (occupancy != 0).
- REQ-016: out = head-block lane selected by lane_idx; out = 0 whenever out_valid = 0.
- REQ-017: lane_idx 0..4 selects in_4, in_3, in_2, in_1, in0 in that order, so samples leave oldest first.
- REQ-018: A sample is consumed when out_valid && out_ready at posedge. lane_idx increments; at 4 it wraps to 0 and the head block pops.
- REQ-019: Latency: a block pushed at edge N into an empty FIFO gives out_valid = 1 and out = in_4 in the cycle after edge N.
- REQ-020: Throughput: 1 sample/cycle sustained with out_ready held high and one block offered at least every 5 cycles; no bubble at block boundaries.
- REQ-021: Simultaneous push and final-lane pop: occupancy is unchanged, the new block is written at the tail, and the head advances.
- REQ-022: Full (occupancy = DEPTH): in_ready = 0. A push attempt is ignored and no data is overwritten.
- REQ-023: out_ready low: out and lane_idx hold their values, and out_valid stays high.
- REQ-024: Control states: EMPTY (occupancy 0), ACTIVE (0 < occupancy < DEPTH), FULL. Transitions follow the push/pop rules above.
- REQ-025: Read and write pointers wrap modulo DEPTH.

Reset
- REQ-026: While reset = 0, asynchronously clear occupancy, pointers, lane_idx, all storage, and sample_cnt; out = 0 and out_valid = 0.
- REQ-027: Reset asserted mid-block discards all buffered samples; the first output after release comes from the next pushed block's in_4.
- REQ-028: Inputs are ignored while reset is asserted.

Configuration
- REQ-029: Macro BLOCK_UNPACKER_CNT_EN. When defined, sample_cnt increments by 1 on every consumed sample and wraps at 2^32. When undefined, the sample_cnt port and its counter are absent.

Structure
- REQ-030: Shared package block_pkg holds DATA_W_DEF = 16, LANES = 5, and the lane-order constants; the package is also used by block_filter and its benches.
- REQ-031: Sub-module block_fifo holds the DEPTH-entry, LANES*DATA_W-wide storage with pointers and occupancy; block_unpacker contains only lane selection and the handshake.

Verification
- REQ-032: After reset release, push in_4..in0 = 0001, 0002, 0003, 0004, 0005 with out_ready = 1 -> out = 0001, 0002, 0003, 0004, 0005 on 5 consecutive cycles, then out_valid = 0.
- REQ-033: Push 3 blocks back-to-back with out_ready = 0 -> in_ready = 0 after the 2nd push; the 3rd block is dropped; releasing out_ready yields exactly 10 samples in order.
- REQ-034: Offer a block every 5 cycles with out_ready = 1 for 200 blocks -> continuous out_valid with no bubble and sample order preserved; with BLOCK_UNPACKER_CNT_EN, sample_cnt = 1000.
- REQ-035: Toggle out_ready 1,0,1,0 mid-block -> out holds during stalls and no sample is repeated or skipped.
- REQ-036: Assert reset after 2 samples of a block -> out_valid = 0 immediately; the next block starts at its in_4.
- REQ-037: Drive block_filter's 1000-sample sine output through the unpacker -> the serial stream matches the reference output file sample-for-sample.
